// File: rtl/conv_pool_frame_sequencer_pkg.sv
// Shared definitions for the conv -> maxpool frame sequencer: state encoding
// and layer-1 frame geometry.
package conv_pool_frame_sequencer_pkg;

    localparam int L1_FRAME_W     = 7;
    localparam int L1_FRAME_H     = 7;
    localparam int L1_FRAME_PIX   = L1_FRAME_W * L1_FRAME_H;
    localparam int L1_FIFO_DEPTH  = 64;
    localparam int L1_FLUSH_BEATS = 8;
    localparam int L1_CNT_W       = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } seq_state_e;

endpackage

// File: rtl/conv_pool_frame_sequencer_occ_counter.sv
// Up/down occupancy counter shared by the four channel FIFOs, with full and
// empty flags derived from the registered count.
module occ_counter
    import conv_pool_frame_sequencer_pkg::*;
#(
    parameter int DEPTH = L1_FIFO_DEPTH,
    parameter int CNT_W = L1_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i) begin
            count_d = count_q + 1'b1;
        end else if (dec_i && !inc_i) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/conv_pool_frame_sequencer.sv
// Counts conv output beats per frame, drains each complete frame from the
// channel FIFOs into the maxpool as one burst, then pushes zero flush beats.
module conv_pool_frame_sequencer
    import conv_pool_frame_sequencer_pkg::*;
#(
    parameter int FRAME_PIX   = L1_FRAME_PIX,
    parameter int FIFO_DEPTH  = L1_FIFO_DEPTH,
    parameter int FLUSH_BEATS = L1_FLUSH_BEATS,
    parameter int CNT_W       = L1_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             conv_valid_i,
    output logic             fifo_write_o,
    output logic             fifo_read_o,
    output logic             pool_valid_in_o,
    output logic             pool_zero_sel_o,
    output logic [CNT_W-1:0] occupancy_o,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic             overflow_o
);

    localparam logic [CNT_W-1:0] FP      = CNT_W'(FRAME_PIX);
    localparam logic [CNT_W-1:0] FP_LAST = CNT_W'(FRAME_PIX - 1);
    localparam logic [CNT_W-1:0] FL_LAST = CNT_W'(FLUSH_BEATS - 1);

    seq_state_e       state_q;
    logic [CNT_W-1:0] wr_cnt_q, pend_cnt_q, rd_cnt_q, fl_cnt_q;
    logic             fifo_read_q, pool_valid_q, pool_zero_q;
    logic             frame_done_q, overflow_q;

    logic [CNT_W-1:0] occ_cnt, load_d;
    logic             occ_full, occ_empty;
    logic             rd_fire, wr_ok, wr_cur, wr_pend, frame_full;

    occ_counter #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_occ (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (wr_ok),
        .dec_i   (rd_fire),
        .count_o (occ_cnt),
        .full_o  (occ_full),
        .empty_o (occ_empty)
    );

    // A read this cycle frees a slot, so a full FIFO can still take a write.
    assign rd_fire    = fifo_read_q & ~occ_empty;
    assign wr_ok      = conv_valid_i & ~(occ_full & ~rd_fire);
    assign wr_cur     = wr_ok & (wr_cnt_q != FP);
    assign wr_pend    = wr_ok & (wr_cnt_q == FP);
    assign frame_full = wr_cur & (wr_cnt_q == FP_LAST);
    assign load_d     = pend_cnt_q + {{(CNT_W-1){1'b0}}, wr_pend};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_cnt_q     <= '0;
            pend_cnt_q   <= '0;
            rd_cnt_q     <= '0;
            fl_cnt_q     <= '0;
            fifo_read_q  <= 1'b0;
            pool_valid_q <= 1'b0;
            pool_zero_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            pool_valid_q <= fifo_read_q;
            pool_zero_q  <= 1'b0;
            if (conv_valid_i && !wr_ok) overflow_q <= 1'b1;
            if (wr_cur)  wr_cnt_q   <= wr_cnt_q + 1'b1;
            if (wr_pend) pend_cnt_q <= pend_cnt_q + 1'b1;

            case (state_q)
                ST_IDLE, ST_FILL: begin
                    if (frame_full) begin
                        state_q     <= ST_DRAIN;
                        fifo_read_q <= 1'b1;
                        rd_cnt_q    <= '0;
                    end else if (wr_ok) begin
                        state_q <= ST_FILL;
                    end
                end
                ST_DRAIN: begin
                    rd_cnt_q <= rd_cnt_q + 1'b1;
                    if (rd_cnt_q == FP_LAST) begin
                        state_q     <= ST_FLUSH;
                        fifo_read_q <= 1'b0;
                        fl_cnt_q    <= '0;
                    end
                end
                ST_FLUSH: begin
                    pool_valid_q <= 1'b1;
                    pool_zero_q  <= 1'b1;
                    fl_cnt_q     <= fl_cnt_q + 1'b1;
                    if (fl_cnt_q == FL_LAST) begin
                        frame_done_q <= 1'b1;
                        // Early beats (including one landing this cycle) seed the next frame;
                        // any excess beyond one frame stays pending.
                        if (load_d >= FP) begin
                            state_q     <= ST_DRAIN;
                            fifo_read_q <= 1'b1;
                            rd_cnt_q    <= '0;
                            wr_cnt_q    <= FP;
                            pend_cnt_q  <= load_d - FP;
                        end else begin
                            state_q    <= (load_d != '0) ? ST_FILL : ST_IDLE;
                            wr_cnt_q   <= load_d;
                            pend_cnt_q <= '0;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign fifo_write_o    = wr_ok;
    assign fifo_read_o     = fifo_read_q;
    assign pool_valid_in_o = pool_valid_q;
    assign pool_zero_sel_o = pool_zero_q;
    assign occupancy_o     = occ_cnt;
    assign busy_o          = (state_q != ST_IDLE);
    assign frame_done_o    = frame_done_q;
    assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_conv_pool_frame_sequencer.sv
// Bench for conv_pool_frame_sequencer: frame-level timeline model, FIFO data
// scoreboard, and directed scenarios with literal expectations.
module tb_conv_pool_frame_sequencer;

    localparam int FP  = 49;
    localparam int DEP = 49;
    localparam int FLB = 8;
    localparam int CW  = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cv  = 1'b0;
    logic fw, fr, pv, pz, busy, fd, ovf;
    logic [CW-1:0] occ;

    always #5 clk = ~clk;

    conv_pool_frame_sequencer #(
        .FRAME_PIX   (FP),
        .FIFO_DEPTH  (DEP),
        .FLUSH_BEATS (FLB),
        .CNT_W       (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .conv_valid_i    (cv),
        .fifo_write_o    (fw),
        .fifo_read_o     (fr),
        .pool_valid_in_o (pv),
        .pool_zero_sel_o (pz),
        .occupancy_o     (occ),
        .busy_o          (busy),
        .frame_done_o    (fd),
        .overflow_o      (ovf)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Frame timeline model: frame k drains from D[k] (after its last beat and
    // after the previous frame's drain+flush), first beat accepted at S[k].
    int cyc = 0;
    int m_occ, m_nacc, m_nfr;
    bit m_ovf;
    int m_D[64];
    int m_S[64];
    bit e_rd, e_pv, e_pz, e_fd, e_bz, e_wr;

    // Data scoreboard: an ideal FIFO with one-cycle read latency.
    int fifo_q[$];
    int wr_tag = 0, exp_tag = 0, dout = 0;
    bit dout_vld;

    // Running observations for the directed scenarios.
    int o_pv = 0, o_fd = 0, o_rd = 0, o_bfall = 0, o_data = 0;
    int last_wr = 0, gap = -1;
    bit prev_rd, prev_busy;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            m_occ = 0; m_nacc = 0; m_nfr = 0; m_ovf = 1'b0;
            fifo_q.delete();
            exp_tag = wr_tag;
            dout_vld = 1'b0; prev_rd = 1'b0; prev_busy = 1'b0;
        end else begin
            e_rd = 0; e_pv = 0; e_pz = 0; e_fd = 0; e_bz = 0;
            for (int k = 0; k < m_nfr; k++) begin
                if (cyc >= m_D[k] && cyc < m_D[k] + FP) e_rd = 1;
                if (cyc > m_D[k] && cyc <= m_D[k] + FP + FLB) e_pv = 1;
                if (cyc > m_D[k] + FP && cyc <= m_D[k] + FP + FLB) e_pz = 1;
                if (cyc == m_D[k] + FP + FLB) e_fd = 1;
                if (cyc > m_S[k] && cyc < m_D[k] + FP + FLB) e_bz = 1;
            end
            if ((m_nacc % FP) != 0 && cyc > m_S[m_nfr]) e_bz = 1;
            e_wr = cv && !(m_occ == DEP && !e_rd);

            chk("fifo_write", int'(fw), int'(e_wr));
            chk("fifo_read", int'(fr), int'(e_rd));
            chk("pool_valid", int'(pv), int'(e_pv));
            chk("pool_zero_sel", int'(pz), int'(e_pz));
            chk("frame_done", int'(fd), int'(e_fd));
            chk("busy", int'(busy), int'(e_bz));
            chk("overflow", int'(ovf), int'(m_ovf));
            chk("occupancy", int'(occ), m_occ);

            if (pv && !pz) begin
                chk("pool_data_ready", int'(dout_vld), 1);
                chk("pool_data_order", dout, exp_tag);
                exp_tag++;
                o_data++;
            end
            dout_vld = 1'b0;
            if (fr) begin
                chk("fifo_nonempty_on_read", int'(fifo_q.size() > 0), 1);
                if (fifo_q.size() > 0) begin
                    dout = fifo_q.pop_front();
                    dout_vld = 1'b1;
                end
            end
            if (fw) begin
                fifo_q.push_back(wr_tag);
                wr_tag++;
            end

            if (pv) o_pv++;
            if (fd) o_fd++;
            if (fr) o_rd++;
            if (fr && !prev_rd) gap = cyc - last_wr;
            if (fw) last_wr = cyc;
            if (prev_busy && !busy) o_bfall++;
            prev_rd = fr;
            prev_busy = busy;

            if (cv && !e_wr) m_ovf = 1'b1;
            m_occ += int'(e_wr) - int'(e_rd);
            if (e_wr) begin
                if ((m_nacc % FP) == 0) m_S[m_nacc / FP] = cyc;
                m_nacc++;
                if ((m_nacc % FP) == 0) begin
                    m_nfr = m_nacc / FP;
                    m_D[m_nfr-1] = cyc + 1;
                    if (m_nfr > 1 && m_D[m_nfr-2] + FP + FLB > cyc + 1)
                        m_D[m_nfr-1] = m_D[m_nfr-2] + FP + FLB;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int n, input int maxgap);
        for (int i = 0; i < n; i++) begin
            cv = 1'b1;
            tick();
            cv = 1'b0;
            if (maxgap > 0) repeat ($urandom_range(0, maxgap)) tick();
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        chk("idle_timeout", int'(n < 400), 1);
        repeat (3) tick();
    endtask

    int b_pv, b_fd, b_rd, b_bf, b_data;

    task automatic snap();
        b_pv = o_pv; b_fd = o_fd; b_rd = o_rd; b_bf = o_bfall; b_data = o_data;
    endtask

    task automatic single_frame(input string tag, input int maxgap);
        snap();
        send(FP, maxgap);
        wait_idle();
        chk({tag, "_pool_beats"}, o_pv - b_pv, FP + FLB);
        chk({tag, "_frame_done"}, o_fd - b_fd, 1);
        chk({tag, "_reads"}, o_rd - b_rd, FP);
        chk({tag, "_drain_gap"}, gap, 1);
        chk({tag, "_occ_end"}, int'(occ), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset_fifo_read", int'(fr), 0);
        chk("reset_pool_valid", int'(pv), 0);
        chk("reset_occupancy", int'(occ), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_overflow", int'(ovf), 0);
        tick();

        // T1 back-to-back frame, T2 gapped frame
        single_frame("t1", 0);
        single_frame("t2", 3);

        // T3 next frame starts 10 cycles into the drain
        snap();
        send(FP, 0);
        repeat (10) tick();
        send(FP, 0);
        wait_idle();
        chk("t3_frame_done", o_fd - b_fd, 2);
        chk("t3_reads", o_rd - b_rd, 2 * FP);
        chk("t3_busy_falls", o_bfall - b_bf, 1);
        chk("t3_drain_gap", gap, 1);

        // T4 conv_valid held through drain into flush with the FIFO full
        snap();
        cv = 1'b1;
        repeat (FP) tick();
        repeat (FP + 2) tick();
        #1;
        chk("t4_write_blocked", int'(fw), 0);
        chk("t4_overflow", int'(ovf), 1);
        chk("t4_occ_sat", int'(occ), DEP);
        cv = 1'b0;
        wait_idle();
        chk("t4_frame_done", o_fd - b_fd, 2);
        chk("t4_overflow_sticky", int'(ovf), 1);

        // T5 reset at the 20th read of a drain
        send(FP, 0);
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t5_fifo_read", int'(fr), 0);
        chk("t5_pool_valid", int'(pv), 0);
        chk("t5_pool_zero", int'(pz), 0);
        chk("t5_occupancy", int'(occ), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_frame_done", int'(fd), 0);
        chk("t5_overflow", int'(ovf), 0);
        tick();
        single_frame("t5b", 0);

        // T6 write and read in every drain cycle
        snap();
        cv = 1'b1;
        repeat (FP + 20) tick();
        #1;
        chk("t6_occ_mid", int'(occ), DEP);
        chk("t6_read_mid", int'(fr), 1);
        chk("t6_write_mid", int'(fw), 1);
        repeat (FP - 20) tick();
        cv = 1'b0;
        wait_idle();
        chk("t6_frame_done", o_fd - b_fd, 2);
        chk("t6_reads", o_rd - b_rd, 2 * FP);
        chk("t6_data_beats", o_data - b_data, 2 * FP);
        chk("t6_overflow", int'(ovf), 0);
        chk("t6_occ_end", int'(occ), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
